sincronizador: RTL and testbench

- Receive-side synchronization stage of the 1000BASE-X PCS (IEEE 802.3 Clause 36, Fig. 36-9).
- Consumes the 10-bit code-group stream produced by the transmit PCS, one code group per clk.
- Acquires and monitors comma alignment, maintains even/odd code-group parity, and declares code_sync_status.
- Forwards code groups with their parity to the downstream receive state machine.

---
 rtl/sync_pkg.sv | 138 +++++++++++++
 rtl/sync_cg_check.sv | 24 ++
 rtl/sincronizador.sv | 111 +++++++++++
 tb/tb_sincronizador.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the 1000BASE-X receive synchronization path:
// state encoding, comma patterns and the 8B/10B code-group tables.
package sync_pkg;

  typedef enum logic [3:0] {
    LOSS_OF_SYNC     = 4'd0,
    COMMA_DETECT_1   = 4'd1,
    COMMA_DETECT_2   = 4'd2,
    COMMA_DETECT_3   = 4'd3,
    ACQUIRE_SYNC_1   = 4'd4,
    ACQUIRE_SYNC_2   = 4'd5,
    SYNC_ACQUIRED_1  = 4'd6,
    SYNC_ACQUIRED_2  = 4'd7,
    SYNC_ACQUIRED_2A = 4'd8,
    SYNC_ACQUIRED_3  = 4'd9,
    SYNC_ACQUIRED_3A = 4'd10,
    SYNC_ACQUIRED_4  = 4'd11,
    SYNC_ACQUIRED_4A = 4'd12
  } sync_state_t;

  localparam logic [6:0] COMMA_P   = 7'b0011111;
  localparam logic [6:0] COMMA_N   = 7'b1100000;
  localparam logic [9:0] K28_5_NEG = 10'b0011111010;
  localparam logic [9:0] K28_5_POS = 10'b1100000101;

  // 5b/6b data sub-blocks (abcdei), returned as {RD- column, RD+ column}.
  function automatic logic [11:0] d6_code(input logic [4:0] x);
    case (x)
      5'd0:  d6_code = {6'b100111, 6'b011000};
      5'd1:  d6_code = {6'b011101, 6'b100010};
      5'd2:  d6_code = {6'b101101, 6'b010010};
      5'd3:  d6_code = {6'b110001, 6'b110001};
      5'd4:  d6_code = {6'b110101, 6'b001010};
      5'd5:  d6_code = {6'b101001, 6'b101001};
      5'd6:  d6_code = {6'b011001, 6'b011001};
      5'd7:  d6_code = {6'b111000, 6'b000111};
      5'd8:  d6_code = {6'b111001, 6'b000110};
      5'd9:  d6_code = {6'b100101, 6'b100101};
      5'd10: d6_code = {6'b010101, 6'b010101};
      5'd11: d6_code = {6'b110100, 6'b110100};
      5'd12: d6_code = {6'b001101, 6'b001101};
      5'd13: d6_code = {6'b101100, 6'b101100};
      5'd14: d6_code = {6'b011100, 6'b011100};
      5'd15: d6_code = {6'b010111, 6'b101000};
      5'd16: d6_code = {6'b011011, 6'b100100};
      5'd17: d6_code = {6'b100011, 6'b100011};
      5'd18: d6_code = {6'b010011, 6'b010011};
      5'd19: d6_code = {6'b110010, 6'b110010};
      5'd20: d6_code = {6'b001011, 6'b001011};
      5'd21: d6_code = {6'b101010, 6'b101010};
      5'd22: d6_code = {6'b011010, 6'b011010};
      5'd23: d6_code = {6'b111010, 6'b000101};
      5'd24: d6_code = {6'b110011, 6'b001100};
      5'd25: d6_code = {6'b100110, 6'b100110};
      5'd26: d6_code = {6'b010110, 6'b010110};
      5'd27: d6_code = {6'b110110, 6'b001001};
      5'd28: d6_code = {6'b001110, 6'b001110};
      5'd29: d6_code = {6'b101110, 6'b010001};
      5'd30: d6_code = {6'b011110, 6'b100001};
      5'd31: d6_code = {6'b101011, 6'b010100};
    endcase
  endfunction

  // 3b/4b data sub-blocks (fghj) keyed by disparity entering the nibble; y=7 is the primary P7.
  function automatic logic [7:0] d4_code(input logic [2:0] y);
    case (y)
      3'd0: d4_code = {4'b1011, 4'b0100};
      3'd1: d4_code = {4'b1001, 4'b1001};
      3'd2: d4_code = {4'b0101, 4'b0101};
      3'd3: d4_code = {4'b1100, 4'b0011};
      3'd4: d4_code = {4'b1101, 4'b0010};
      3'd5: d4_code = {4'b1010, 4'b1010};
      3'd6: d4_code = {4'b0110, 4'b0110};
      3'd7: d4_code = {4'b1110, 4'b0001};
    endcase
  endfunction

  // The twelve special code groups, {RD- column, RD+ column}.
  function automatic logic [19:0] k_code(input logic [3:0] i);
    case (i)
      4'd0:    k_code = {10'b0011110100, 10'b1100001011};
      4'd1:    k_code = {10'b0011111001, 10'b1100000110};
      4'd2:    k_code = {10'b0011110101, 10'b1100001010};
      4'd3:    k_code = {10'b0011110011, 10'b1100001100};
      4'd4:    k_code = {10'b0011110010, 10'b1100001101};
      4'd5:    k_code = {K28_5_NEG, K28_5_POS};
      4'd6:    k_code = {10'b0011110110, 10'b1100001001};
      4'd7:    k_code = {10'b0011111000, 10'b1100000111};
      4'd8:    k_code = {10'b1110101000, 10'b0001010111};
      4'd9:    k_code = {10'b1101101000, 10'b0010010111};
      4'd10:   k_code = {10'b1011101000, 10'b0100010111};
      4'd11:   k_code = {10'b0111101000, 10'b1000010111};
      default: k_code = '0;
    endcase
  endfunction

  // True when cg equals the encoding of some data byte in either disparity column.
  function automatic logic cg_is_data(input logic [9:0] cg);
    logic [11:0] e6;
    logic [7:0]  e4;
    logic [5:0]  c6;
    logic [3:0]  c4;
    logic        rd4;
    logic        alt;
    cg_is_data = 1'b0;
    for (int unsigned x = 0; x < 32; x++) begin
      e6 = d6_code(5'(x));
      for (int unsigned rd = 0; rd < 2; rd++) begin
        c6  = (rd == 0) ? e6[11:6] : e6[5:0];
        // Balanced sub-blocks keep the disparity; unbalanced ones flip it for the nibble.
        rd4 = ($countones(c6) == 3) ? rd[0] : ~rd[0];
        alt = rd4 ? (x == 11 || x == 13 || x == 14) : (x == 17 || x == 18 || x == 20);
        for (int unsigned y = 0; y < 8; y++) begin
          e4 = d4_code(3'(y));
          c4 = rd4 ? e4[3:0] : e4[7:4];
          if (y == 7 && alt) c4 = rd4 ? 4'b1000 : 4'b0111;
          if (c6 == cg[9:4] && c4 == cg[3:0]) cg_is_data = 1'b1;
        end
      end
    end
  endfunction

  function automatic logic cg_is_special(input logic [9:0] cg);
    logic [19:0] k;
    cg_is_special = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      k = k_code(4'(i));
      if (cg == k[19:10] || cg == k[9:0]) cg_is_special = 1'b1;
    end
  endfunction

  function automatic logic sync_ok(input sync_state_t s);
    sync_ok = s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                        SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4,
                        SYNC_ACQUIRED_4A};
  endfunction

endpackage

// File: rtl/sync_cg_check.sv
// Combinational code-group classifier: comma pattern, table validity and data/special split.
module sync_cg_check
  import sync_pkg::*;
#(
  parameter int unsigned CG_W = 10
) (
  input  logic [CG_W-1:0] rx_code_group,
  output logic            comma,
  output logic            valid,
  output logic            is_data
);

  logic data_hit;
  logic special_hit;

  always_comb begin
    comma       = (rx_code_group[9:3] == COMMA_P) || (rx_code_group[9:3] == COMMA_N);
    data_hit    = cg_is_data(rx_code_group);
    special_hit = cg_is_special(rx_code_group);
    is_data     = data_hit;
    valid       = data_hit || special_hit;
  end

endmodule

// File: rtl/sincronizador.sv
// 1000BASE-X receive synchronization: comma acquisition, code-group parity tracking
// and code_sync_status, with a one-clock registered forward of the code group.
module sincronizador
  import sync_pkg::*;
#(
  parameter int unsigned CG_W         = 10,
  parameter int unsigned GOOD_CGS_MAX = 3
) (
  input  logic            clk,
  input  logic            mr_main_reset,
  input  logic            signal_detect,
  input  logic [CG_W-1:0] rx_code_group,
  output logic            code_sync_status,
  output logic            rx_even,
  output logic [CG_W-1:0] sync_code_group,
  output logic            sync_cg_comma
);

  localparam int unsigned GC_W = (GOOD_CGS_MAX < 1) ? 1 : $clog2(GOOD_CGS_MAX + 1);
  localparam logic [GC_W-1:0] GC_MAX = GC_W'(GOOD_CGS_MAX);
  localparam logic [GC_W-1:0] GC_ONE = GC_W'(1);

  sync_state_t     state, state_nxt;
  logic [GC_W-1:0] good_cgs, gc_nxt;
  logic            comma, valid, is_data;
  logic            cgbad, cggood;
  logic            even_nxt;

  sync_cg_check #(.CG_W(CG_W)) u_cg_check (
    .rx_code_group (rx_code_group),
    .comma         (comma),
    .valid         (valid),
    .is_data       (is_data)
  );

  always_comb begin
    cgbad     = !valid || (comma && rx_even);
    cggood    = !cgbad;
    state_nxt = state;
    gc_nxt    = '0;
    if (!signal_detect) begin
      state_nxt = LOSS_OF_SYNC;
    end else begin
      case (state)
        LOSS_OF_SYNC:    if (comma) state_nxt = COMMA_DETECT_1;
        COMMA_DETECT_1:  state_nxt = is_data ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
        COMMA_DETECT_2:  state_nxt = is_data ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
        COMMA_DETECT_3:  state_nxt = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
        ACQUIRE_SYNC_1: begin
          if (cgbad)                  state_nxt = LOSS_OF_SYNC;
          else if (comma && !rx_even) state_nxt = COMMA_DETECT_2;
        end
        ACQUIRE_SYNC_2: begin
          if (cgbad)                  state_nxt = LOSS_OF_SYNC;
          else if (comma && !rx_even) state_nxt = COMMA_DETECT_3;
        end
        SYNC_ACQUIRED_1: if (cgbad) state_nxt = SYNC_ACQUIRED_2;
        SYNC_ACQUIRED_2: begin
          state_nxt = cggood ? SYNC_ACQUIRED_2A : SYNC_ACQUIRED_3;
          if (cggood) gc_nxt = GC_ONE;
        end
        SYNC_ACQUIRED_3: begin
          state_nxt = cggood ? SYNC_ACQUIRED_3A : SYNC_ACQUIRED_4;
          if (cggood) gc_nxt = GC_ONE;
        end
        SYNC_ACQUIRED_4: begin
          state_nxt = cggood ? SYNC_ACQUIRED_4A : LOSS_OF_SYNC;
          if (cggood) gc_nxt = GC_ONE;
        end
        // In the nA states the counter only survives while staying put.
        SYNC_ACQUIRED_2A: begin
          if (cgbad)                  state_nxt = SYNC_ACQUIRED_3;
          else if (good_cgs == GC_MAX) state_nxt = SYNC_ACQUIRED_1;
          else                        gc_nxt    = good_cgs + GC_ONE;
        end
        SYNC_ACQUIRED_3A: begin
          if (cgbad)                  state_nxt = SYNC_ACQUIRED_4;
          else if (good_cgs == GC_MAX) state_nxt = SYNC_ACQUIRED_2;
          else                        gc_nxt    = good_cgs + GC_ONE;
        end
        SYNC_ACQUIRED_4A: begin
          if (cgbad)                  state_nxt = LOSS_OF_SYNC;
          else if (good_cgs == GC_MAX) state_nxt = SYNC_ACQUIRED_3;
          else                        gc_nxt    = good_cgs + GC_ONE;
        end
        default:         state_nxt = LOSS_OF_SYNC;
      endcase
    end
    even_nxt = (state_nxt inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
               ? 1'b1 : ~rx_even;
  end

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state            <= LOSS_OF_SYNC;
      good_cgs         <= '0;
      rx_even          <= 1'b0;
      code_sync_status <= 1'b0;
      sync_code_group  <= '0;
      sync_cg_comma    <= 1'b0;
    end else begin
      state            <= state_nxt;
      good_cgs         <= gc_nxt;
      rx_even          <= even_nxt;
      code_sync_status <= sync_ok(state_nxt);
      sync_code_group  <= rx_code_group;
      sync_cg_comma    <= comma;
    end
  end

endmodule

// File: tb/tb_sincronizador.sv
// Directed-vector bench for sincronizador: stimulus pushes hand-derived expectations,
// an independent monitor pops and compares one entry per consumed code group.
module tb_sincronizador;

  localparam logic [9:0] K = 10'b0011111010;  // K28.5 RD-
  localparam logic [9:0] D = 10'b1001000101;  // D16.2 RD+
  localparam logic [9:0] E = 10'b1010101010;  // D21.5
  localparam logic [9:0] B = 10'b0000000000;  // not in any table

  typedef struct packed {
    int         idx;
    logic [9:0] cg;
    logic       comma;
    logic       st;
    logic       ev;
  } exp_t;

  logic       clk = 1'b0;
  logic       mr_main_reset = 1'b1;
  logic       signal_detect = 1'b1;
  logic [9:0] rx_code_group = '0;
  logic       code_sync_status;
  logic       rx_even;
  logic [9:0] sync_code_group;
  logic       sync_cg_comma;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_n    = 0;

  always #5 clk = ~clk;

  sincronizador #(.CG_W(10), .GOOD_CGS_MAX(3)) dut (
    .clk              (clk),
    .mr_main_reset    (mr_main_reset),
    .signal_detect    (signal_detect),
    .rx_code_group    (rx_code_group),
    .code_sync_status (code_sync_status),
    .rx_even          (rx_even),
    .sync_code_group  (sync_code_group),
    .sync_cg_comma    (sync_cg_comma)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_status"}, 32'(code_sync_status), 32'd0);
    chk({tag, "_even"},   32'(rx_even),          32'd0);
    chk({tag, "_cg"},     32'(sync_code_group),  32'd0);
    chk({tag, "_comma"},  32'(sync_cg_comma),    32'd0);
  endtask

  // Called at a negedge; drives one code group and returns at the next negedge.
  task automatic v(input logic [9:0] cg, input logic sd, input logic st, input logic ev);
    exp_t e;
    rx_code_group = cg;
    signal_detect = sd;
    e.idx   = vec_n;
    e.cg    = cg;
    e.comma = (cg == K);
    e.st    = st;
    e.ev    = ev;
    sb.push_back(e);
    vec_n++;
    @(negedge clk);
  endtask

  task automatic acquire();
    v(K, 1'b1, 1'b0, 1'b1);
    v(D, 1'b1, 1'b0, 1'b0);
    v(K, 1'b1, 1'b0, 1'b1);
    v(D, 1'b1, 1'b0, 1'b0);
    v(K, 1'b1, 1'b0, 1'b1);
    v(D, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("v%0d_status", e.idx), 32'(code_sync_status), 32'(e.st));
        chk($sformatf("v%0d_even",   e.idx), 32'(rx_even),          32'(e.ev));
        chk($sformatf("v%0d_cg",     e.idx), 32'(sync_code_group),  32'(e.cg));
        chk($sformatf("v%0d_comma",  e.idx), 32'(sync_cg_comma),    32'(e.comma));
      end
    end
  end

  initial begin : stim
    int waited;
    rx_code_group = K;
    #1 mr_main_reset = 1'b0;
    #1 chk_reset_outputs("rst_hold0");
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst_hold3");
    mr_main_reset = 1'b1;

    // acquisition, then one invalid group followed by four good ones
    acquire();
    v(B, 1'b1, 1'b1, 1'b1);
    v(E, 1'b1, 1'b1, 1'b0);
    v(D, 1'b1, 1'b1, 1'b1);
    v(E, 1'b1, 1'b1, 1'b0);
    v(D, 1'b1, 1'b1, 1'b1);
    // four invalid groups from SYNC_ACQUIRED_1
    v(B, 1'b1, 1'b1, 1'b0);
    v(B, 1'b1, 1'b1, 1'b1);
    v(B, 1'b1, 1'b1, 1'b0);
    v(B, 1'b1, 1'b0, 1'b1);
    // commas in odd slots
    acquire();
    v(D, 1'b1, 1'b1, 1'b1);
    v(K, 1'b1, 1'b1, 1'b0);
    v(D, 1'b1, 1'b1, 1'b1);
    v(K, 1'b1, 1'b1, 1'b0);
    v(D, 1'b1, 1'b1, 1'b1);
    v(K, 1'b1, 1'b1, 1'b0);
    v(D, 1'b1, 1'b1, 1'b1);
    v(K, 1'b1, 1'b0, 1'b0);
    // even-slot comma in sync is good, then signal_detect drops
    acquire();
    v(K, 1'b1, 1'b1, 1'b1);
    v(D, 1'b1, 1'b1, 1'b0);
    v(K, 1'b0, 1'b0, 1'b1);
    v(K, 1'b0, 1'b0, 1'b0);
    acquire();

    // asynchronous reset mid-operation
    chk("sb_drained", 32'(sb.size()), 32'd0);
    #2 mr_main_reset = 1'b0;
    #1 chk_reset_outputs("rst_mid");
    @(negedge clk);
    chk_reset_outputs("rst_mid_hold");
    mr_main_reset = 1'b1;
    v(K, 1'b1, 1'b0, 1'b1);
    v(K, 1'b1, 1'b0, 1'b0);
    v(K, 1'b1, 1'b0, 1'b1);
    v(D, 1'b1, 1'b0, 1'b0);
    v(B, 1'b1, 1'b0, 1'b1);
    v(D, 1'b1, 1'b0, 1'b0);

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
